// File: rtl/vga_pkg.sv
// Shared VGA capture definitions: default 720p totals, capture FSM states
// and the colour/frame-length helpers used by the capture controller.
package vga_pkg;

  localparam int HTOTAL_DEF = 1650;
  localparam int VTOTAL_DEF = 750;
  localparam int PIX_W      = 21;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

  function automatic logic [PIX_W-1:0] frame_pixels(input int htotal, input int vtotal);
    return PIX_W'(htotal * vtotal);
  endfunction

  function automatic logic [7:0] expand4(input logic [3:0] c);
    return {c, c};
  endfunction

  localparam logic [PIX_W-1:0] FRAME_PIXELS = frame_pixels(HTOTAL_DEF, VTOTAL_DEF);

endpackage

// File: rtl/vga_capture_ctrl_frame_len_checker.sv
// Counts pixels of each captured frame and flags (stickily) any frame whose
// length differs from the nominal total when the next frame start arrives.
module frame_len_checker
  import vga_pkg::*;
#(
  parameter logic [PIX_W-1:0] FRAME_LEN = FRAME_PIXELS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic active,
  input  logic fs,
  output logic sync_err
);

  localparam logic [PIX_W-1:0] PIX_MAX = 21'h1F_FFFF;

  logic [PIX_W-1:0] pix_cnt_r;
  logic             sync_err_r;

  // The fs cycle itself is pixel 1 of the new frame, hence the reload to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r  <= 21'd0;
      sync_err_r <= 1'b0;
    end else if (start) begin
      pix_cnt_r  <= 21'd1;
    end else if (active) begin
      if (fs) begin
        pix_cnt_r <= 21'd1;
        if (pix_cnt_r != FRAME_LEN) begin
          sync_err_r <= 1'b1;
        end
      end else if (pix_cnt_r != PIX_MAX) begin
        pix_cnt_r <= pix_cnt_r + 21'd1;
      end
    end
  end

  assign sync_err = sync_err_r;

endmodule

// File: rtl/vga_capture_ctrl.sv
// Capture controller feeding the frame writer: expands 4-bit VGA colour to
// 8 bits and frames the capture with one-cycle go pulses at frame start.
module vga_capture_ctrl
  import vga_pkg::*;
#(
  parameter int HTOTAL      = HTOTAL_DEF,
  parameter int VTOTAL      = VTOTAL_DEF,
  parameter int SKIP_FRAMES = 1,
  parameter int NUM_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [11:0] rgb_in,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        go,
  output logic        busy,
  output logic        done,
  output logic [7:0]  frame_cnt,
  output logic        sync_err
);

  localparam logic [PIX_W-1:0] FRAME_LEN = frame_pixels(HTOTAL, VTOTAL);
  localparam logic [7:0]       SKIP_LIM  = 8'(SKIP_FRAMES);
  localparam logic [7:0]       NUM_LIM   = 8'(NUM_FRAMES);

  capture_state_t state_r;
  logic [7:0]     skip_cnt_r;
  logic [7:0]     frame_cnt_r;
  logic           go_r;
  logic           busy_r;
  logic           done_r;
  logic [7:0]     r_r;
  logic [7:0]     g_r;
  logic [7:0]     b_r;
  logic           fs_s;
  logic           start_s;
  logic           active_s;

  assign fs_s     = (hcount == 11'd0) && (vcount == 11'd0);
  assign start_s  = (state_r == SKIP) && fs_s && (skip_cnt_r == SKIP_LIM);
  assign active_s = (state_r == CAPTURE);

  // Colour expansion, registered every cycle so it lines up with go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= 8'd0;
      g_r <= 8'd0;
      b_r <= 8'd0;
    end else begin
      r_r <= expand4(rgb_in[11:8]);
      g_r <= expand4(rgb_in[7:4]);
      b_r <= expand4(rgb_in[3:0]);
    end
  end

  // Capture sequencing; busy/done are updated alongside the state they decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      skip_cnt_r  <= 8'd0;
      frame_cnt_r <= 8'd0;
      go_r        <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      go_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r    <= SKIP;
            skip_cnt_r <= 8'd0;
          end
        end
        SKIP: begin
          if (fs_s) begin
            if (skip_cnt_r == SKIP_LIM) begin
              state_r <= CAPTURE;
              go_r    <= 1'b1;
              busy_r  <= 1'b1;
            end else begin
              skip_cnt_r <= skip_cnt_r + 8'd1;
            end
          end
        end
        CAPTURE: begin
          if (fs_s) begin
            go_r        <= 1'b1;
            frame_cnt_r <= frame_cnt_r + 8'd1;
            if ((frame_cnt_r + 8'd1) == NUM_LIM) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  frame_len_checker #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_len_checker (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_s),
    .active   (active_s),
    .fs       (fs_s),
    .sync_err (sync_err)
  );

  assign r         = r_r;
  assign g         = g_r;
  assign b         = b_r;
  assign go        = go_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_vga_capture_ctrl.sv
// Directed bench for vga_capture_ctrl on an 8x4 raster: two instances share
// the stimulus, one with SKIP=1/NUM=2 and one with SKIP=0/NUM=1.
module tb_vga_capture_ctrl;

  localparam int HT = 8;
  localparam int VT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [11:0] rgb_in;

  logic [7:0] r_a, g_a, b_a, frame_cnt_a;
  logic       go_a, busy_a, done_a, sync_err_a;
  logic [7:0] r_b, g_b, b_b, frame_cnt_b;
  logic       go_b, busy_b, done_b, sync_err_b;

  vga_capture_ctrl #(.HTOTAL(HT), .VTOTAL(VT), .SKIP_FRAMES(1), .NUM_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hcount(hcount), .vcount(vcount),
    .rgb_in(rgb_in), .r(r_a), .g(g_a), .b(b_a), .go(go_a), .busy(busy_a),
    .done(done_a), .frame_cnt(frame_cnt_a), .sync_err(sync_err_a)
  );

  vga_capture_ctrl #(.HTOTAL(HT), .VTOTAL(VT), .SKIP_FRAMES(0), .NUM_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hcount(hcount), .vcount(vcount),
    .rgb_in(rgb_in), .r(r_b), .g(g_b), .b(b_b), .go(go_b), .busy(busy_b),
    .done(done_b), .frame_cnt(frame_cnt_b), .sync_err(sync_err_b)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          fs_idx;
  int          gos_a[$];
  int          gos_b[$];
  int          dbl_a, dbl_b, busy_b_cyc, go_any, busy_any;
  logic        pg_a, pg_b;
  logic [23:0] rgb_at_go_a;
  bit          got_rgb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [11:0] pix_rgb(input int h, input int v);
    if (h == 0 && v == 0) return 12'hA5C;
    else return {4'(h), 4'(v), 4'h7};
  endfunction

  // One pixel clock: apply inputs, clock, sample 1 ns later and log go/busy.
  task automatic step(input int h, input int v, input logic [11:0] c);
    hcount = 11'(h);
    vcount = 11'(v);
    rgb_in = c;
    if (h == 0 && v == 0) fs_idx++;
    @(posedge clk);
    #1;
    if (go_a) begin
      gos_a.push_back(fs_idx);
      if (!got_rgb) begin
        rgb_at_go_a = {r_a, g_a, b_a};
        got_rgb     = 1'b1;
      end
    end
    if (go_b) gos_b.push_back(fs_idx);
    if (go_a && pg_a) dbl_a++;
    if (go_b && pg_b) dbl_b++;
    pg_a = go_a;
    pg_b = go_b;
    if (busy_b) busy_b_cyc++;
    if (go_a || go_b) go_any++;
    if (busy_a || busy_b) busy_any++;
    enable = 1'b0;
  endtask

  task automatic drive(input int p0, input int len);
    for (int p = p0; p < p0 + len; p++) step(p % HT, p / HT, pix_rgb(p % HT, p / HT));
  endtask

  task automatic clear_log();
    fs_idx = -1;
    gos_a.delete();
    gos_b.delete();
    dbl_a = 0; dbl_b = 0; busy_b_cyc = 0; go_any = 0; busy_any = 0;
    pg_a = 1'b0; pg_b = 1'b0; got_rgb = 1'b0; rgb_at_go_a = 24'd0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    hcount = 11'd5;
    vcount = 11'd2;
    rgb_in = 12'hFFF;
    clear_log();
    #2;
    check("reset_a", {r_a, g_a, b_a, go_a, busy_a, done_a, frame_cnt_a, sync_err_a}, 64'd0);
    check("reset_b", {r_b, g_b, b_b, go_b, busy_b, done_b, frame_cnt_b, sync_err_b}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // enable held low for five frames
    clear_log();
    for (int f = 0; f < 4; f++) drive(0, HT * VT);
    drive(0, 11);
    step(3, 1, pix_rgb(3, 1));
    check("idle_rgb_a", {r_a, g_a, b_a}, 24'h331177);
    check("idle_rgb_b", {r_b, g_b, b_b}, 24'h331177);
    drive(12, 20);
    check("idle_no_go", go_any, 0);
    check("idle_no_busy", busy_any, 0);
    check("idle_no_done", {done_a, done_b}, 2'b00);

    // ideal run: enable pulse coincides with a frame start
    clear_log();
    enable = 1'b1;
    for (int f = 0; f < 5; f++) drive(0, HT * VT);
    check("a_go_count", gos_a.size(), 3);
    for (int i = 0; i < gos_a.size() && i < 3; i++) check($sformatf("a_go_fs%0d", i), gos_a[i], i + 2);
    check("a_go_width", dbl_a, 0);
    check("a_rgb_at_go", rgb_at_go_a, 24'hAA55CC);
    check("a_done", {done_a, busy_a}, 2'b10);
    check("a_frame_cnt", frame_cnt_a, 8'd2);
    check("a_sync_err", sync_err_a, 1'b0);
    check("b_go_count", gos_b.size(), 2);
    for (int i = 0; i < gos_b.size() && i < 2; i++) check($sformatf("b_go_fs%0d", i), gos_b[i], i + 1);
    check("b_go_width", dbl_b, 0);
    check("b_busy_cycles", busy_b_cyc, 32);
    check("b_done", {done_b, busy_b}, 2'b10);
    check("b_frame_cnt", frame_cnt_b, 8'd1);
    check("b_sync_err", sync_err_b, 1'b0);

    // second captured frame cut to 31 pixels
    pulse_reset();
    clear_log();
    enable = 1'b1;
    for (int f = 0; f < 3; f++) drive(0, HT * VT);
    drive(0, 31);
    check("short_pre_err", sync_err_a, 1'b0);
    check("short_pre_cnt", frame_cnt_a, 8'd1);
    step(0, 0, pix_rgb(0, 0));
    check("short_err", sync_err_a, 1'b1);
    check("short_cnt", frame_cnt_a, 8'd2);
    check("short_go", go_a, 1'b1);
    drive(1, 31);
    check("short_err_sticky", sync_err_a, 1'b1);

    // asynchronous reset in the middle of the second captured frame
    pulse_reset();
    clear_log();
    enable = 1'b1;
    for (int f = 0; f < 3; f++) drive(0, HT * VT);
    drive(0, 10);
    check("mid_pre", {busy_a, frame_cnt_a}, {1'b1, 8'd1});
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", {r_a, g_a, b_a, go_a, busy_a, done_a, frame_cnt_a, sync_err_a}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
    enable = 1'b1;
    drive(0, HT * VT);
    drive(0, HT * VT);
    check("rearm_skip", {busy_a, go_a, frame_cnt_a}, {1'b0, 1'b0, 8'd0});
    step(0, 0, pix_rgb(0, 0));
    check("rearm_start", {busy_a, go_a, frame_cnt_a}, {1'b1, 1'b1, 8'd0});
    drive(1, 31);
    step(0, 0, pix_rgb(0, 0));
    check("rearm_cnt", frame_cnt_a, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_capture_ctrl.md
# vga_capture_ctrl

Synthesizable-style capture controller sitting directly upstream of the testbench TIFF frame writer. It taps the design's 12-bit VGA output bus and drives the writer's 8-bit r/g/b inputs, expanding 4-bit to 8-bit colour. It generates the one-cycle `go` pulses that open and close each frame file, aligned to frame start. It skips a configurable number of warm-up frames, captures a bounded number of frames, and checks every captured frame's length against the nominal total.

## Interface
- `HTOTAL`, 1650, total pixels per line including blanking (writer XDIM)
- `VTOTAL`, 750, total lines per frame including blanking (writer YDIM)
- `SKIP_FRAMES`, 1, frame starts discarded after enable before capture begins
- `NUM_FRAMES`, 2, frames to capture (≥1)

Ports:
- `clk`  in  1  pixel clock; single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  arm request, sampled only in IDLE
- `hcount`  in  11  current pixel column from VGA timing
- `vcount`  in  11  current line from VGA timing
- `rgb_in`  in  12  {R[3:0],G[3:0],B[3:0]} for current pixel
- `r`, `g`, `b`  out  8  expanded colour, registered
- `go`  out  1  frame boundary pulse to writer
- `busy`  out  1  high in CAPTURE
- `done`  out  1  high in DONE
- `frame_cnt`  out  8  captured frames completed
- `sync_err`  out  1  sticky: a captured frame length ≠ HTOTAL*VTOTAL

## Operation
- Frame start (fs): combinational `hcount==0 && vcount==0`.
- Expansion: r={R,R}, g={G,G}, b={B,B}. Registered every cycle in every state.
- FSM states are IDLE, SKIP, CAPTURE and DONE.
- IDLE: `enable`=1 moves to SKIP and clears skip_cnt.
- SKIP: on fs, if skip_cnt==SKIP_FRAMES, go to CAPTURE, pulse `go` and load pix_cnt=1. Otherwise increment skip_cnt. With SKIP_FRAMES=0, the first fs starts capture.
- CAPTURE: pix_cnt increments each non-fs cycle and saturates at 2^21−1.
- CAPTURE on fs:
  - pulse `go`.
  - If pix_cnt≠HTOTAL*VTOTAL, set `sync_err`.
  - Increment `frame_cnt`.
  - Reload pix_cnt=1.
  - If the new frame_cnt==NUM_FRAMES, go to DONE; this `go` is the closing pulse.
- DONE: no further `go`. Held until reset. `enable` is ignored outside IDLE; deasserting it never aborts.
- Pulse count: exactly NUM_FRAMES+1 `go` pulses per run.
- The writer re-arms on the closing pulse, so the bench ends simulation once `done` rises.
- Widths: pix_cnt is 21 bits, because 1650*750=1,237,500 < 2^21. HTOTAL*VTOTAL is computed as a 21-bit constant. frame_cnt wraps modulo 256 (unreachable if NUM_FRAMES≤255).

## Timing
- Reset values (asynchronously, on `rst_n` low): r=g=b=0, go=0, busy=0, done=0, frame_cnt=0, sync_err=0, state IDLE, all counters 0.
- Latency: one cycle from `hcount`/`vcount`/`rgb_in` to `r`/`g`/`b`/`go`. `go` rises in the same cycle that pixel (0,0) appears on r/g/b. The writer samples on negedge, so pixel (0,0) is the first byte written.
- `go` is high exactly one cycle, never two consecutive cycles.
- `busy` and `done` are registered state decodes and change in the cycle after the fs that causes the transition.
- If `enable` rises in the same cycle as fs, that fs is not counted; the IDLE→SKIP transition takes priority.
- If `rst_n` is asserted mid-CAPTURE, outputs clear immediately and the partial frame is abandoned with no closing `go`.

## Structure
- Shared `vga_pkg`:
  - HTOTAL/VTOTAL defaults (existing 720p timing constants)
  - `capture_state_t` enum {IDLE, SKIP, CAPTURE, DONE}
  - `FRAME_PIXELS` = HTOTAL*VTOTAL
- Natural sub-module: `frame_len_checker`, holding pix_cnt, saturation, compare at fs and sticky `sync_err`.
- FSM, expansion register and `go` register stay in the top.

## Test plan
- Reset, then HTOTAL=8, VTOTAL=4, SKIP_FRAMES=1, NUM_FRAMES=2, enable=1 with ideal timing. Required: `go` at the 2nd, 3rd and 4th fs only, each one cycle wide; `done`=1 and `frame_cnt`=2 after the 4th fs; `sync_err`=0.
- rgb_in=12'hA5C at (0,0). Required: next cycle r=8'hAA, g=8'h55, b=8'hCC, with `go`=1 in the same cycle.
- SKIP_FRAMES=0, NUM_FRAMES=1. Required: `go` at the 1st and 2nd fs; `busy` high for exactly 32 cycles.
- Second captured frame shortened to 31 pixels (early fs). Required: `sync_err`=1 after that fs and staying 1; frame_cnt still increments.
- Assert `rst_n` low mid-CAPTURE. Required: all outputs 0 asynchronously; after release with enable=1, SKIP restarts and frame_cnt restarts from 0.
- `enable` low throughout 5 frames. Required: no `go`, `busy`=0, r/g/b still track rgb_in with one-cycle latency.
